// File: rtl/hnf_txreq_arb.sv
// ----------------------------------------------------------------------------
// hnf_txreq_arb
//   Shares the HN-F outbound CHI TXREQ link between NUM_REQ internal
//   requesters. It owns the TXREQ link-layer credit counter, picks one
//   requester per cycle by round-robin when a credit is held, and registers
//   the granted flit onto TXREQFLIT/TXREQFLITV.
//
// Ports
//   clock          : sole clock, rising edge
//   reset          : asynchronous, active-high reset
//   req_valid      : per-requester flit valid
//   req_flit       : per-requester flit, requester i at [i*FLIT_W +: FLIT_W]
//   req_ready      : one-hot grant (combinational), handshake = valid & ready
//   TXREQFLIT      : outbound flit (registered)
//   TXREQFLITV     : outbound flit valid (registered)
//   TXREQFLITPEND  : flit-pending, held high from the first edge after reset
//   TXREQLCRDV     : one link credit returned per cycle high
//   crd_cnt        : current credit count
//   crd_ovf_err    : sticky, credit received while count was at MAX_CRD
// ----------------------------------------------------------------------------
module hnf_txreq_arb #(
  parameter int NUM_REQ = 2,
  parameter int FLIT_W  = 64,
  parameter int MAX_CRD = 15
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*FLIT_W-1:0] req_flit,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [FLIT_W-1:0]         TXREQFLIT,
  output logic                      TXREQFLITV,
  output logic                      TXREQFLITPEND,
  input  logic                      TXREQLCRDV,
  output logic [3:0]                crd_cnt,
  output logic                      crd_ovf_err
);

  localparam int             IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W+1)'(NUM_REQ);
  localparam logic [3:0]     MAX_CRD_W = 4'(MAX_CRD);

  logic [IDX_W-1:0]  last_grant_r;
  logic [3:0]        crd_cnt_r;
  logic              crd_ovf_err_r;
  logic [FLIT_W-1:0] flit_r;
  logic              flitv_r;
  logic              pend_r;

  logic              found_s;
  logic [IDX_W-1:0]  grant_idx_s;
  logic              crd_avail_s;
  logic              hs_s;
  logic [FLIT_W-1:0] sel_flit_s;
  logic [NUM_REQ-1:0] req_ready_s;

  // Only registered credits count; a credit returned this cycle is usable next cycle.
  assign crd_avail_s = (crd_cnt_r != 4'd0);
  assign hs_s        = found_s & crd_avail_s;

  // Round-robin search: first valid requester starting one past the last grant, wrapping.
  always_comb begin
    logic [IDX_W:0]   sum_v;
    logic [IDX_W:0]   wrap_v;
    logic [IDX_W-1:0] cand_v;
    found_s     = 1'b0;
    grant_idx_s = last_grant_r;
    sum_v       = '0;
    wrap_v      = '0;
    cand_v      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      sum_v  = {1'b0, last_grant_r} + (IDX_W+1)'(k);
      wrap_v = sum_v - NUM_REQ_W;
      cand_v = (sum_v >= NUM_REQ_W) ? wrap_v[IDX_W-1:0] : sum_v[IDX_W-1:0];
      if (!found_s && req_valid[cand_v]) begin
        found_s     = 1'b1;
        grant_idx_s = cand_v;
      end else begin
        found_s     = found_s;
      end
    end
  end

  // Select the flit of the winning requester.
  always_comb begin
    sel_flit_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx_s == IDX_W'(i)) begin
        sel_flit_s = req_flit[i*FLIT_W +: FLIT_W];
      end else begin
        sel_flit_s = sel_flit_s;
      end
    end
  end

  // One-hot ready to the winner, only when a credit is held.
  always_comb begin
    req_ready_s = '0;
    if (hs_s) begin
      req_ready_s[grant_idx_s] = 1'b1;
    end else begin
      req_ready_s = '0;
    end
  end

  assign req_ready = req_ready_s;

  // Link-side registers: flit/valid, pend, credit counter, rr pointer, sticky error.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      flit_r        <= '0;
      flitv_r       <= 1'b0;
      pend_r        <= 1'b0;
      crd_cnt_r     <= 4'd0;
      crd_ovf_err_r <= 1'b0;
      last_grant_r  <= '0;
    end else begin
      pend_r  <= 1'b1;
      flitv_r <= hs_s;
      if (hs_s) begin
        flit_r       <= sel_flit_s;
        last_grant_r <= grant_idx_s;
      end
      // A credit returned in the same cycle as a send cancels out.
      case ({TXREQLCRDV, hs_s})
        2'b10: begin
          if (crd_cnt_r == MAX_CRD_W) begin
            crd_ovf_err_r <= 1'b1;
          end else begin
            crd_cnt_r <= crd_cnt_r + 4'd1;
          end
        end
        2'b01:   crd_cnt_r <= crd_cnt_r - 4'd1;
        default: crd_cnt_r <= crd_cnt_r;
      endcase
    end
  end

  assign TXREQFLIT     = flit_r;
  assign TXREQFLITV    = flitv_r;
  assign TXREQFLITPEND = pend_r;
  assign crd_cnt       = crd_cnt_r;
  assign crd_ovf_err   = crd_ovf_err_r;

endmodule

// File: tb/tb_hnf_txreq_arb.sv
// ----------------------------------------------------------------------------
// tb_hnf_txreq_arb
//   Randomized + directed bench for hnf_txreq_arb. A reference model (credit
//   integer, last-winner integer, per-requester pending flags) predicts the
//   grant each cycle and pushes the expected flit into a queue; a separate
//   monitor pops that queue against TXREQFLIT/TXREQFLITV.
// ----------------------------------------------------------------------------
module tb_hnf_txreq_arb;

  localparam int N    = 3;
  localparam int W    = 16;
  localparam int MAXC = 15;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [N-1:0]     req_valid = '0;
  logic [N*W-1:0]   req_flit = '0;
  logic [N-1:0]     req_ready;
  logic [W-1:0]     TXREQFLIT;
  logic             TXREQFLITV;
  logic             TXREQFLITPEND;
  logic             TXREQLCRDV = 1'b0;
  logic [3:0]       crd_cnt;
  logic             crd_ovf_err;

  hnf_txreq_arb #(.NUM_REQ(N), .FLIT_W(W), .MAX_CRD(MAXC)) dut (
    .clock         (clock),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_flit      (req_flit),
    .req_ready     (req_ready),
    .TXREQFLIT     (TXREQFLIT),
    .TXREQFLITV    (TXREQFLITV),
    .TXREQFLITPEND (TXREQFLITPEND),
    .TXREQLCRDV    (TXREQLCRDV),
    .crd_cnt       (crd_cnt),
    .crd_ovf_err   (crd_ovf_err)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int         m_crd  = 0;
  int         m_last = 0;
  bit         m_ovf  = 1'b0;
  bit         m_pend = 1'b0;
  logic [W-1:0] m_flit = '0;
  logic [W-1:0] exp_q[$];
  bit         pvalid [N];
  logic [W-1:0] pflit [N];
  int         last_win = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit crd);
    for (int i = 0; i < N; i++) begin
      req_valid[i]       = pvalid[i];
      req_flit[i*W +: W] = pflit[i];
    end
    TXREQLCRDV = crd;
  endtask

  // Model step at the falling edge: check registered state, predict grant, advance.
  task automatic step();
    int win;
    logic [N-1:0] exp_rdy;
    win = -1;
    check("crd_cnt", 64'(crd_cnt), 64'(m_crd));
    check("crd_ovf_err", 64'(crd_ovf_err), 64'(m_ovf));
    check("txreq_pend", 64'(TXREQFLITPEND), 64'(m_pend));
    if (m_crd > 0) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (win < 0 && pvalid[c]) win = c;
      end
    end
    exp_rdy = '0;
    if (win >= 0) exp_rdy[win] = 1'b1;
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    last_win = win;
    if (win >= 0) begin
      exp_q.push_back(pflit[win]);
      m_last      = win;
      pvalid[win] = 1'b0;
    end
    if (TXREQLCRDV && win < 0) begin
      if (m_crd == MAXC) m_ovf = 1'b1;
      else m_crd++;
    end else if (!TXREQLCRDV && win >= 0) begin
      m_crd--;
    end
    m_pend = 1'b1;
  endtask

  // One clock: optionally raise new random requests, drive, check at negedge.
  task automatic cycle(input bit crd, input int prob);
    for (int i = 0; i < N; i++) begin
      if (!pvalid[i] && $urandom_range(0, 99) < prob) begin
        pvalid[i] = 1'b1;
        pflit[i]  = W'($urandom);
      end
    end
    drive(crd);
    @(negedge clock);
    step();
    @(posedge clock);
    #1;
  endtask

  task automatic raise(input int i, input logic [W-1:0] f);
    pvalid[i] = 1'b1;
    pflit[i]  = f;
  endtask

  // Asynchronous reset mid-cycle, held across one rising edge.
  task automatic do_reset();
    #2;
    reset = 1'b1;
    m_crd  = 0;
    m_last = 0;
    m_ovf  = 1'b0;
    m_pend = 1'b0;
    m_flit = '0;
    exp_q.delete();
    #1;
    check("rst_flitv", 64'(TXREQFLITV), 64'd0);
    check("rst_flit", 64'(TXREQFLIT), 64'd0);
    check("rst_pend", 64'(TXREQFLITPEND), 64'd0);
    check("rst_crd", 64'(crd_cnt), 64'd0);
    check("rst_ovf", 64'(crd_ovf_err), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd0);
    @(posedge clock);
    #2;
    reset = 1'b0;
  endtask

  // Monitor: every flit predicted by the model must appear the next cycle, nothing else.
  always @(posedge clock) begin
    logic [W-1:0] e;
    #1;
    if (!reset) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        m_flit = e;
        check("txreq_v", 64'(TXREQFLITV), 64'd1);
        check("txreq_flit", 64'(TXREQFLIT), 64'(e));
      end else begin
        check("txreq_v_idle", 64'(TXREQFLITV), 64'd0);
        check("txreq_flit_hold", 64'(TXREQFLIT), 64'(m_flit));
      end
    end
  end

  int exp_rr [4] = '{1, 0, 1, 0};

  initial begin
    for (int i = 0; i < N; i++) begin
      pvalid[i] = 1'b0;
      pflit[i]  = '0;
    end
    #1;
    check("init_flitv", 64'(TXREQFLITV), 64'd0);
    check("init_crd", 64'(crd_cnt), 64'd0);
    check("init_pend", 64'(TXREQFLITPEND), 64'd0);
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b0;

    // credits accumulate with no traffic
    repeat (3) cycle(1'b1, 0);
    cycle(1'b0, 0);
    check("crd_three", 64'(crd_cnt), 64'd3);

    // single send with one credit
    do_reset();
    cycle(1'b1, 0);
    raise(0, 16'h00A5);
    cycle(1'b0, 0);
    check("single_grant", 64'(last_win), 64'd0);
    check("single_flit", 64'(TXREQFLIT), 64'h00A5);
    raise(0, 16'h0077);
    repeat (2) cycle(1'b0, 0);
    cycle(1'b1, 0);
    repeat (2) cycle(1'b0, 0);

    // round-robin fairness between requesters 0 and 1
    do_reset();
    repeat (4) cycle(1'b1, 0);
    for (int j = 0; j < 4; j++) begin
      if (!pvalid[0]) raise(0, W'(16'h1000 + j));
      if (!pvalid[1]) raise(1, W'(16'h2000 + j));
      cycle(1'b0, 0);
      check("rr_order", 64'(last_win), 64'(exp_rr[j]));
    end
    check("rr_crd_end", 64'(crd_cnt), 64'd0);
    pvalid[0] = 1'b0;
    pvalid[1] = 1'b0;
    cycle(1'b0, 0);

    // simultaneous credit return and send
    do_reset();
    cycle(1'b1, 0);
    raise(2, 16'h0C0C);
    cycle(1'b1, 0);
    raise(0, 16'h0D0D);
    cycle(1'b0, 0);
    check("simul_next_grant", 64'(last_win), 64'd0);
    cycle(1'b0, 0);

    // overflow: 16 credits with no traffic
    do_reset();
    repeat (16) cycle(1'b1, 0);
    repeat (2) cycle(1'b0, 0);
    check("ovf_sat", 64'(crd_cnt), 64'd15);
    check("ovf_flag", 64'(crd_ovf_err), 64'd1);
    repeat (20) cycle(1'b0, 60);
    check("ovf_sticky", 64'(crd_ovf_err), 64'd1);

    // mid-stream reset with requester 1 continuously valid
    do_reset();
    repeat (5) cycle(1'b1, 0);
    for (int j = 0; j < 3; j++) begin
      if (!pvalid[1]) raise(1, W'(16'h3000 + j));
      cycle(1'b0, 0);
    end
    if (!pvalid[1]) raise(1, 16'h3333);
    drive(1'b0);
    do_reset();
    repeat (3) cycle(1'b0, 0);
    check("post_rst_ready", 64'(req_ready), 64'd0);
    cycle(1'b1, 0);
    cycle(1'b0, 0);

    // randomized traffic
    for (int c = 0; c < 2000; c++) begin
      if (c == 1000) do_reset();
      cycle(($urandom_range(0, 99) < 45) ? 1'b1 : 1'b0, 40);
    end
    for (int i = 0; i < N; i++) pvalid[i] = 1'b0;
    repeat (3) cycle(1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hnf_txreq_arb.md
Name: hnf_txreq_arb

Overview:
- Shares the HN-F outbound TXREQ link between NUM_REQ internal requesters, e.g. the SLC miss path issuing ReadNoSnp and POCQ retry/replay.
- Owns the CHI link-layer credit counter for TXREQ.
- Selects one requester per cycle by round-robin and registers the granted flit onto TXREQFLIT/TXREQFLITV.
- Sits between the slc_txreq pipe stage and the CHI TXREQ pins.

Parameters:
- NUM_REQ, 2, number of requesters (>=2).
- FLIT_W, width of reqflit_t, request flit width in bits.
- MAX_CRD, 15, maximum link credits the receiver may grant (CHI limit).

Ports:
- clock  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester flit valid.
- req_flit  input  NUM_REQ*FLIT_W  per-requester flit; requester i occupies bits [i*FLIT_W +: FLIT_W].
- req_ready  output  NUM_REQ  one-hot grant; handshake on req_valid[i] & req_ready[i].
- TXREQFLIT  output  FLIT_W  outbound flit, registered.
- TXREQFLITV  output  1  outbound flit valid, registered.
- TXREQFLITPEND  output  1  flit-pending indication.
- TXREQLCRDV  input  1  one link credit returned per cycle high.
- crd_cnt  output  4  current credit count (status/debug).
- crd_ovf_err  output  1  sticky error: credit received while count == MAX_CRD.

Behaviour:
- Reset values, asynchronous: TXREQFLIT=0, TXREQFLITV=0, TXREQFLITPEND=0, crd_cnt=0, crd_ovf_err=0, rr pointer=0. req_ready is combinational and is therefore 0 while crd_cnt==0.
- TXREQFLITPEND: registered; 1 from the first clock edge after reset deassertion, then held high. CHI permits a permanently asserted pend.
- Credit counter:
  - TXREQLCRDV alone: +1.
  - Flit sent alone: -1.
  - Both in the same cycle: unchanged.
  - TXREQLCRDV at MAX_CRD with no send: count holds at MAX_CRD and crd_ovf_err sets. crd_ovf_err clears only on reset.
  - A send never occurs at count 0, so no underflow.
- Grant eligibility: crd_cnt > 0. A credit arriving in cycle T is usable from T+1, never combinationally.
- Arbitration:
  - Round-robin over req_valid.
  - Search starts at index (last_grant+1) mod NUM_REQ and wraps.
  - At most one req_ready high per cycle; req_ready[i] is high only if req_valid[i] is high and a credit is available.
  - req_ready depends combinationally on req_valid; requesters must not make req_valid depend on req_ready.
- Pointer update: last_grant updates only on a handshake. With no handshake the pointer holds, so an idle cycle does not rotate priority.
- Latency:
  - Handshake in cycle T puts the flit on TXREQFLIT with TXREQFLITV=1 in T+1. Credit decrements at the T edge.
  - Back-to-back grants give one flit per cycle while credits last.
  - With no handshake in T, TXREQFLITV=0 in T+1 and TXREQFLIT holds its last value.
- Requester rules: once req_valid rises it must stay high with req_flit stable until its handshake. The block never drops or reorders a granted flit.
- Reset mid-operation:
  - Asynchronous reset clears everything, including any in-flight TXREQFLITV and all credits.
  - Per CHI, the link is re-initialised by the receiver re-granting credits.
- No backpressure on the pins: flit transmission is governed only by credits, so TXREQFLITV is never stalled.

Test Plan:
- Credits: after reset, pulse TXREQLCRDV 3 cycles with req_valid=0 -> crd_cnt=3, req_ready=0, TXREQFLITV=0.
- Single send: 1 credit, req_valid[0]=1 with flit 0xA5 -> req_ready[0]=1 that cycle; next cycle TXREQFLIT=0xA5, TXREQFLITV=1; crd_cnt=0; req_ready=0 until a new credit.
- Round-robin fairness: NUM_REQ=2, both valid, 4 credits -> grants alternate 0,1,0,1 (pointer starts at 0 so requester 1 goes first if valid: expect 1,0,1,0); crd_cnt ends at 0.
- Simultaneous credit and send: crd_cnt=1, both TXREQLCRDV=1 and a handshake in the same cycle -> crd_cnt stays 1; the next request is granted the following cycle.
- Overflow: drive 16 credits with no traffic -> crd_cnt saturates at 15; crd_ovf_err=1 and stays 1 until reset.
- Mid-stream reset: 5 credits, continuous valid on requester 1, assert reset for 1 cycle -> all outputs 0 immediately; after deassertion, req_ready stays 0 until new credits arrive.
